// File: rtl/frame_reassembler_pkg.sv
// Shared definitions for the egress frame reassembler.
// Holds the header word field map, the frame length bounds and the FSM
// state encoding used by frame_reassembler and its header serializer.
package frame_reassembler_pkg;

   localparam int HEADER_DWIDTH = 128;

   localparam int DST_MSB   = 127;
   localparam int DST_LSB   = 80;
   localparam int SRC_MSB   = 79;
   localparam int SRC_LSB   = 32;
   localparam int ETYPE_MSB = 31;
   localparam int ETYPE_LSB = 16;
   localparam int RSVD_MSB  = 15;
   localparam int RSVD_LSB  = 4;
   localparam int PORT_MSB  = 3;
   localparam int PORT_LSB  = 0;

   // dst + src + EtherType, the part of the header word that goes on the wire
   localparam int HDR_BITS      = DST_MSB - ETYPE_LSB + 1;
   localparam int ETH_HDR_BYTES = 14;

   localparam int MIN_FRAME = 60;
   localparam int MAX_FRAME = 1514;
   localparam int LEN_W     = 11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HWAIT,
      ST_HLOAD,
      ST_HDR,
      ST_BODY,
      ST_DRAIN,
      ST_PAD,
      ST_DONE
   } state_t;

endpackage

// File: rtl/frame_reassembler_hdr_serializer.sv
// Header serializer: loads the 112 wire bits of a header word and shifts
// them out one byte per shift_en, most significant byte first.
// Ports:
//   clk, arst_n  clock and asynchronous active-low reset
//   load         capture hdr_bits, restart the byte index
//   hdr_bits     dst MAC, src MAC, EtherType (concatenated)
//   shift_en     advance to the next byte
//   byte_out     current header byte
//   last_byte    byte_out is the 14th header byte
module frame_reassembler_hdr_serializer
   import frame_reassembler_pkg::*;
(
   input  logic                clk,
   input  logic                arst_n,
   input  logic                load,
   input  logic [HDR_BITS-1:0] hdr_bits,
   input  logic                shift_en,
   output logic [7:0]          byte_out,
   output logic                last_byte
);

   logic [HDR_BITS-1:0] shreg;
   logic [3:0]          idx;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         shreg <= '0;
         idx   <= '0;
      end else if (load) begin
         shreg <= hdr_bits;
         idx   <= '0;
      end else if (shift_en) begin
         shreg <= {shreg[HDR_BITS-9:0], 8'h00};
         idx   <= idx + 4'd1;
      end
   end

   assign byte_out  = shreg[HDR_BITS-1 -: 8];
   assign last_byte = (idx == 4'(ETH_HDR_BYTES - 1));

endmodule

// File: rtl/frame_reassembler.sv
// Egress frame reassembler: pops a header word, emits its 14 header bytes,
// streams the body bytes up to the body end-of-data mark, pads runts to
// MIN_FRAME bytes and truncates frames beyond MAX_FRAME bytes.
// Ports:
//   clk, arst_n                         clock, asynchronous active-low reset
//   h_fifo_dout/empty, h_fifo_rden      header FIFO (data one cycle after pop)
//   b_fifo_dout/del/empty, b_fifo_rden  body FIFO (data one cycle after pop)
//   o_fifo_din/wren/del, o_fifo_afull   byte-wide output FIFO
//   src_port                            ingress port of the current frame
//   frame_done, trunc_err               end-of-frame pulses
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | wait for a header and output room, pop the header
// HWAIT    | header pop in flight
// HLOAD    | header word valid: load serializer, latch src_port
// HDR      | write the 14 header bytes
// BODY     | pop/write body bytes until del or MAX_FRAME
// DRAIN    | discard the rest of a truncated body up to its del
// PAD      | write zero bytes up to MIN_FRAME
// DONE     | pulse frame_done / trunc_err
module frame_reassembler
   import frame_reassembler_pkg::*;
(
   input  logic                     clk,
   input  logic                     arst_n,
   input  logic [HEADER_DWIDTH-1:0] h_fifo_dout,
   input  logic                     h_fifo_empty,
   output logic                     h_fifo_rden,
   input  logic [7:0]               b_fifo_dout,
   input  logic                     b_fifo_del,
   input  logic                     b_fifo_empty,
   output logic                     b_fifo_rden,
   output logic [7:0]               o_fifo_din,
   output logic                     o_fifo_wren,
   output logic                     o_fifo_del,
   input  logic                     o_fifo_afull,
   output logic [3:0]               src_port,
   output logic                     frame_done,
   output logic                     trunc_err
);

   localparam logic [LEN_W-1:0] MIN_CNT = LEN_W'(MIN_FRAME);
   localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_FRAME);

   state_t           state;
   logic [LEN_W-1:0] byte_cnt;
   logic [LEN_W-1:0] cnt_inc;
   logic             trunc_flag;

   // b_vld: FIFO data is valid this cycle; skid_*: a returned byte held
   // across an afull stall
   logic             b_vld;
   logic             skid_vld;
   logic [7:0]       skid_byte;
   logic             skid_del;

   logic             in_body;
   logic             avail;
   logic [7:0]       cur_byte;
   logic             cur_del;
   logic             consume;
   logic             ending;
   logic             pop_ok;

   logic [HDR_BITS-1:0] hdr_bits;
   logic [7:0]          ser_byte;
   logic                ser_last;
   logic                ser_load;
   logic                ser_shift;
   logic                unused_rsvd;

   assign hdr_bits  = {h_fifo_dout[DST_MSB:DST_LSB],
                       h_fifo_dout[SRC_MSB:SRC_LSB],
                       h_fifo_dout[ETYPE_MSB:ETYPE_LSB]};
   assign unused_rsvd = ^h_fifo_dout[RSVD_MSB:RSVD_LSB];
   assign ser_load  = (state == ST_HLOAD);
   assign ser_shift = (state == ST_HDR) && !o_fifo_afull;
   assign cnt_inc   = byte_cnt + LEN_W'(1);

   frame_reassembler_hdr_serializer u_hdr_ser (
      .clk       (clk),
      .arst_n    (arst_n),
      .load      (ser_load),
      .hdr_bits  (hdr_bits),
      .shift_en  (ser_shift),
      .byte_out  (ser_byte),
      .last_byte (ser_last)
   );

   // At most one body pop is outstanding. The next pop may be issued in the
   // same cycle the previous byte is consumed, giving one byte per 2 cycles,
   // unless that byte ends the body phase.
   always_comb begin
      in_body  = (state == ST_BODY) || (state == ST_DRAIN);
      avail    = skid_vld || b_vld;
      cur_byte = skid_vld ? skid_byte : b_fifo_dout;
      cur_del  = skid_vld ? skid_del : b_fifo_del;
      consume  = in_body && avail && !o_fifo_afull;
      ending   = 1'b0;
      if (consume) begin
         if (state == ST_BODY) ending = cur_del || (cnt_inc == MAX_CNT);
         else                  ending = cur_del;
      end
      pop_ok = in_body && !o_fifo_afull && !b_fifo_empty && !b_fifo_rden
               && (!avail || consume) && !ending;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         b_vld     <= 1'b0;
         skid_vld  <= 1'b0;
         skid_byte <= '0;
         skid_del  <= 1'b0;
      end else begin
         b_vld <= b_fifo_rden;
         if (b_vld && o_fifo_afull) begin
            skid_vld  <= 1'b1;
            skid_byte <= b_fifo_dout;
            skid_del  <= b_fifo_del;
         end else if (consume) begin
            skid_vld <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state       <= ST_IDLE;
         byte_cnt    <= '0;
         trunc_flag  <= 1'b0;
         h_fifo_rden <= 1'b0;
         b_fifo_rden <= 1'b0;
         o_fifo_din  <= '0;
         o_fifo_wren <= 1'b0;
         o_fifo_del  <= 1'b0;
         src_port    <= '0;
         frame_done  <= 1'b0;
         trunc_err   <= 1'b0;
      end else begin
         h_fifo_rden <= 1'b0;
         b_fifo_rden <= pop_ok;
         o_fifo_wren <= 1'b0;
         o_fifo_del  <= 1'b0;
         frame_done  <= 1'b0;
         trunc_err   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!h_fifo_empty && !o_fifo_afull) begin
                  h_fifo_rden <= 1'b1;
                  state       <= ST_HWAIT;
               end
            end
            ST_HWAIT: state <= ST_HLOAD;
            ST_HLOAD: begin
               src_port <= h_fifo_dout[PORT_MSB:PORT_LSB];
               byte_cnt <= '0;
               state    <= ST_HDR;
            end
            ST_HDR: begin
               if (!o_fifo_afull) begin
                  o_fifo_wren <= 1'b1;
                  o_fifo_din  <= ser_byte;
                  byte_cnt    <= cnt_inc;
                  if (ser_last) state <= ST_BODY;
               end
            end
            ST_BODY: begin
               if (consume) begin
                  o_fifo_wren <= 1'b1;
                  o_fifo_din  <= cur_byte;
                  byte_cnt    <= cnt_inc;
                  if (cur_del) begin
                     if (cnt_inc < MIN_CNT) begin
                        state <= ST_PAD;
                     end else begin
                        o_fifo_del <= 1'b1;
                        state      <= ST_DONE;
                     end
                  end else if (cnt_inc == MAX_CNT) begin
                     o_fifo_del <= 1'b1;
                     trunc_flag <= 1'b1;
                     state      <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (consume && cur_del) state <= ST_DONE;
            end
            ST_PAD: begin
               if (!o_fifo_afull) begin
                  o_fifo_wren <= 1'b1;
                  o_fifo_din  <= 8'h00;
                  byte_cnt    <= cnt_inc;
                  if (cnt_inc == MIN_CNT) begin
                     o_fifo_del <= 1'b1;
                     state      <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               frame_done <= 1'b1;
               trunc_err  <= trunc_flag;
               trunc_flag <= 1'b0;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/frame_reassembler.md
Name: frame_reassembler

Overview:
- Egress-side counterpart of the MAC decoder's header/body split.
- Pops one 128-bit header word from the header FIFO, serialises it back into the 14 Ethernet header bytes, then streams the matching body bytes from the body packet FIFO up to the body end-of-data mark.
- Pads runt frames to 60 bytes, truncates frames longer than 1514 bytes, and writes the result into a byte-wide frame FIFO with an end-of-data strobe.
- Sits in the 100 MHz clk domain, between the header/body FIFOs and any port TX frame FIFO or CPU egress path.

Parameters:
- HEADER_DWIDTH, 128, header word width; layout fixed: [127:80] dst MAC, [79:32] src MAC, [31:16] EtherType, [15:4] reserved, [3:0] ingress port one-hot.
- MIN_FRAME, 60, minimum emitted bytes excluding FCS; zero padding applied below this.
- MAX_FRAME, 1514, maximum emitted bytes; body bytes beyond this are discarded.
- LEN_W, 11, width of the byte counter.

Ports:
- clk  in  1  100 MHz system clock
- arst_n  in  1  asynchronous active-low reset
- h_fifo_dout  in  HEADER_DWIDTH  header word, valid the cycle after h_fifo_rden
- h_fifo_empty  in  1  header FIFO empty
- h_fifo_rden  out  1  header pop strobe
- b_fifo_dout  in  8  body byte, valid the cycle after b_fifo_rden
- b_fifo_del  in  1  end-of-data flag, valid alongside b_fifo_dout; marks the last body byte
- b_fifo_empty  in  1  body FIFO empty
- b_fifo_rden  out  1  body pop strobe
- o_fifo_din  out  8  output byte
- o_fifo_wren  out  1  output write strobe
- o_fifo_del  out  1  end-of-data strobe, asserted together with o_fifo_wren on the last byte
- o_fifo_afull  in  1  output FIFO almost full; stall
- src_port  out  4  ingress port of the current frame, held until the next header pop
- frame_done  out  1  one-cycle pulse after the last byte is written
- trunc_err  out  1  one-cycle pulse with frame_done when truncation occurred

Behaviour:
- All outputs are registered.
- Reset values: all strobes 0, o_fifo_din 0, src_port 0, state IDLE, counters 0.
- Reset asserted mid-frame aborts the frame immediately; no o_fifo_del is issued. The downstream FIFO is reset by the same arst_n.
- IDLE: if !h_fifo_empty && !o_fifo_afull, pulse h_fifo_rden for one cycle, then go to HLOAD.
- HLOAD: latch h_fifo_dout into the shift register, set src_port = [3:0], set byte_cnt = 0, go to HDR.
- HDR: when !o_fifo_afull, write one byte per cycle, MSB first: dst[47:40] first, EtherType[7:0] as the 14th byte. byte_cnt increments per write. After the 14th byte, go to BODY.
- BODY: a body pop is issued only when !b_fifo_empty && !o_fifo_afull and no pop is outstanding (pop-pending flag).
  - A returned byte is written the cycle after the pop, with byte_cnt++.
  - Throughput: one byte per 2 cycles. A pipelined 1 byte/cycle implementation is permitted if o_fifo_afull margin is at least 2.
- Returned byte with b_fifo_del=1:
  - byte_cnt+1 < MIN_FRAME: write the byte with o_fifo_del=0, go to PAD.
  - otherwise: write it with o_fifo_del=1, go to DONE.
- byte_cnt reaches MAX_FRAME before del is seen:
  - The MAX_FRAME-th byte is written with o_fifo_del=1.
  - Set trunc flag, go to DRAIN.
- DRAIN: pop body bytes (o_fifo_wren=0) until a returned byte has b_fifo_del=1, then go to DONE.
- PAD: write 0x00 per cycle when !o_fifo_afull. o_fifo_del=1 on byte MIN_FRAME, then go to DONE.
- DONE: pulse frame_done (and trunc_err if the flag is set), clear the flag, return to IDLE.
- Stall: o_fifo_afull holds all writes and pops; state and counters are frozen. A byte already returned from a pop is held in a skid register and written once afull drops.
- Body FIFO empty mid-frame: wait in BODY/DRAIN indefinitely with no timeout; o_fifo_wren stays 0.
- A header with an empty body (del on the first body byte) still emits at least 60 bytes via PAD.
- Simultaneous header-not-empty and DONE: the next frame starts the cycle after returning to IDLE. Header pops never overlap with a frame in progress.
- byte_cnt is LEN_W bits wide and never wraps (the MAX_FRAME bound < 2^LEN_W).

Decomposition:
- Shared package: header field bit positions (DST_MSB/LSB, SRC_*, ETYPE_*, PORT_*), ETH_HDR_BYTES=14, MIN_FRAME, MAX_FRAME, and the state encoding.
- One natural sub-module, hdr_serializer: 128→8 shift register with load, shift-enable and last-byte indication.
- The FSM and counters live in the top.

Test Plan:
- Header dst=FF:FF:FF:FF:FF:FF, src=00:11:22:33:44:55, type 0x0800, port 4'b0010; 46-byte body 0x00..0x2D with del on the last byte -> 60 writes, bytes 0-13 match the header order, del on write 60, src_port=2, frame_done pulse, no trunc_err.
- Same header with a 10-byte body -> 24 data bytes followed by 36 bytes of 0x00, del on byte 60.
- 1600-byte body -> exactly 1514 writes, del on write 1514, remaining 100 bytes popped without writes, trunc_err=1 with frame_done.
- o_fifo_afull toggled every 3 cycles during BODY -> byte stream identical to the unstalled case, no duplicates or drops.
- Two headers queued back-to-back -> the second h_fifo_rden occurs only after the first frame_done; frames do not interleave.
- arst_n pulsed low at byte 20 -> all strobes 0 immediately; after release a fresh header produces a correct full frame.
